// File: rtl/sdf_pkg.sv
// SDF firing controller shared types.
// State encoding and default token width.
package sdf_pkg;

  localparam int DW_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONSUME,
    ST_PRODUCE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sdf_rate_counter.sv
// 8-bit beat counter for one stream of an SDF firing.
// hit flags the final beat; complete stays set until clr.
module sdf_rate_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       beat,
  input  logic [7:0] target,
  output logic       hit,
  output logic       complete
);

  logic [7:0] count_q;

  assign hit = beat && (count_q == target);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      complete <= 1'b0;
    end else if (clr) begin
      count_q  <= '0;
      complete <= 1'b0;
    end else if (beat) begin
      if (hit) begin
        count_q  <= '0;
        complete <= 1'b1;
      end else begin
        count_q  <= count_q + 8'd1;
      end
    end
  end

endmodule

// File: rtl/sdf_fire_ctrl.sv
// Firing controller for one SDF actor: gates one input
// and two output streams at fixed token rates per firing.
module sdf_fire_ctrl
  import sdf_pkg::*;
#(
  parameter int DATA_W     = DW_DEFAULT,
  parameter int CONS_RATE  = 1,
  parameter int PROD1_RATE = 1,
  parameter int PROD2_RATE = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic [15:0]       n_fire,
  output logic              busy,
  output logic              done,
  output logic [15:0]       fire_count,
  input  logic [DATA_W-1:0] up_s0_data,
  input  logic              up_s0_valid,
  output logic              up_s0_ready,
  output logic [DATA_W-1:0] act_s0_data,
  output logic              act_s0_valid,
  input  logic              act_s0_ready,
  input  logic [DATA_W-1:0] act_s1_data,
  input  logic              act_s1_valid,
  output logic              act_s1_ready,
  output logic [DATA_W-1:0] dn_s1_data,
  output logic              dn_s1_valid,
  input  logic              dn_s1_ready,
  input  logic [DATA_W-1:0] act_s2_data,
  input  logic              act_s2_valid,
  output logic              act_s2_ready,
  output logic [DATA_W-1:0] dn_s2_data,
  output logic              dn_s2_valid,
  input  logic              dn_s2_ready
);

  localparam logic [7:0] TGT0 = 8'(CONS_RATE - 1);
  localparam logic [7:0] TGT1 = 8'(PROD1_RATE - 1);
  localparam logic [7:0] TGT2 = 8'(PROD2_RATE - 1);

  state_t      state_q, state_d;
  logic [15:0] n_lat_q, fire_q;
  logic        start_acc, prod_done, clr, last;
  logic        s0_en, s1_en, s2_en;
  logic        beat0, beat1, beat2;
  logic        hit0, hit1, hit2;
  logic        cmpl0, cmpl1, cmpl2;

  assign s0_en = (state_q == ST_CONSUME) && !cmpl0;
  assign s1_en = (state_q == ST_PRODUCE) && !cmpl1;
  assign s2_en = (state_q == ST_PRODUCE) && !cmpl2;

  assign act_s0_data  = up_s0_data;
  assign act_s0_valid = s0_en && up_s0_valid;
  assign up_s0_ready  = s0_en && act_s0_ready;
  assign dn_s1_data   = act_s1_data;
  assign dn_s1_valid  = s1_en && act_s1_valid;
  assign act_s1_ready = s1_en && dn_s1_ready;
  assign dn_s2_data   = act_s2_data;
  assign dn_s2_valid  = s2_en && act_s2_valid;
  assign act_s2_ready = s2_en && dn_s2_ready;

  assign beat0 = act_s0_valid && act_s0_ready;
  assign beat1 = dn_s1_valid && dn_s1_ready;
  assign beat2 = dn_s2_valid && dn_s2_ready;

  // a channel finishes either earlier or on this very beat
  assign prod_done = (state_q == ST_PRODUCE)
                  && (cmpl1 || hit1)
                  && (cmpl2 || hit2);
  assign clr  = start_acc || prod_done;
  assign last = (fire_q + 16'd1) == n_lat_q;

  assign busy       = (state_q == ST_CONSUME)
                   || (state_q == ST_PRODUCE);
  assign done       = (state_q == ST_DONE);
  assign fire_count = fire_q;

  sdf_rate_counter u_cnt0 (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .clr      (clr),
    .beat     (beat0),
    .target   (TGT0),
    .hit      (hit0),
    .complete (cmpl0)
  );

  sdf_rate_counter u_cnt1 (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .clr      (clr),
    .beat     (beat1),
    .target   (TGT1),
    .hit      (hit1),
    .complete (cmpl1)
  );

  sdf_rate_counter u_cnt2 (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .clr      (clr),
    .beat     (beat2),
    .target   (TGT2),
    .hit      (hit2),
    .complete (cmpl2)
  );

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = (n_fire == 16'd0) ? ST_DONE
                                        : ST_CONSUME;
        end
      end
      ST_CONSUME: begin
        if (hit0) state_d = ST_PRODUCE;
      end
      ST_PRODUCE: begin
        if (prod_done) state_d = last ? ST_DONE
                                      : ST_CONSUME;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= ST_IDLE;
      n_lat_q <= '0;
      fire_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        n_lat_q <= n_fire;
        fire_q  <= '0;
      end else if (prod_done) begin
        fire_q  <= fire_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sdf_fire_ctrl.sv
// Directed bench for sdf_fire_ctrl: three rate configs
// driven in sequence, beats tallied by a stream monitor.
module tb_sdf_fire_ctrl;

  localparam int CR [3] = '{2, 1, 1};
  localparam int P1 [3] = '{1, 1, 2};
  localparam int P2 [3] = '{3, 1, 2};

  logic clk;
  logic rst;

  logic [2:0] start, busy, done;
  logic [2:0] up_s0_valid, up_s0_ready;
  logic [2:0] act_s0_valid, act_s0_ready;
  logic [2:0] act_s1_valid, act_s1_ready;
  logic [2:0] dn_s1_valid, dn_s1_ready;
  logic [2:0] act_s2_valid, act_s2_ready;
  logic [2:0] dn_s2_valid, dn_s2_ready;
  logic [15:0] n_fire [3];
  logic [15:0] fire_count [3];
  logic [31:0] up_s0_data [3];
  logic [31:0] act_s0_data [3];
  logic [31:0] act_s1_data [3];
  logic [31:0] dn_s1_data [3];
  logic [31:0] act_s2_data [3];
  logic [31:0] dn_s2_data [3];

  int checks;
  int fails;
  int n0 [3], n1 [3], n2 [3], nv [3], nd [3];
  int b0, b1, b2, bv, bd;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sdf_fire_ctrl #(
      .DATA_W     (32),
      .CONS_RATE  (CR[g]),
      .PROD1_RATE (P1[g]),
      .PROD2_RATE (P2[g])
    ) u_dut (
      .clk_clk      (clk),
      .reset_reset  (rst),
      .start        (start[g]),
      .n_fire       (n_fire[g]),
      .busy         (busy[g]),
      .done         (done[g]),
      .fire_count   (fire_count[g]),
      .up_s0_data   (up_s0_data[g]),
      .up_s0_valid  (up_s0_valid[g]),
      .up_s0_ready  (up_s0_ready[g]),
      .act_s0_data  (act_s0_data[g]),
      .act_s0_valid (act_s0_valid[g]),
      .act_s0_ready (act_s0_ready[g]),
      .act_s1_data  (act_s1_data[g]),
      .act_s1_valid (act_s1_valid[g]),
      .act_s1_ready (act_s1_ready[g]),
      .dn_s1_data   (dn_s1_data[g]),
      .dn_s1_valid  (dn_s1_valid[g]),
      .dn_s1_ready  (dn_s1_ready[g]),
      .act_s2_data  (act_s2_data[g]),
      .act_s2_valid (act_s2_valid[g]),
      .act_s2_ready (act_s2_ready[g]),
      .dn_s2_data   (dn_s2_data[g]),
      .dn_s2_valid  (dn_s2_valid[g]),
      .dn_s2_ready  (dn_s2_ready[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (act_s0_valid[i] && act_s0_ready[i]) n0[i]++;
      if (dn_s1_valid[i] && dn_s1_ready[i]) n1[i]++;
      if (dn_s2_valid[i] && dn_s2_ready[i]) n2[i]++;
      if (act_s0_valid[i] || up_s0_ready[i] ||
          dn_s1_valid[i] || act_s1_ready[i] ||
          dn_s2_valid[i] || act_s2_ready[i]) nv[i]++;
      if (done[i]) nd[i]++;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input int i);
    b0 = n0[i]; b1 = n1[i]; b2 = n2[i];
    bv = nv[i]; bd = nd[i];
  endtask

  task automatic pulse(input int i, input logic [15:0] n);
    n_fire[i] = n;
    start[i]  = 1'b1;
    tick();
    start[i]  = 1'b0;
  endtask

  task automatic wait_done(input int i, input string tag);
    int k;
    k = 0;
    while (!done[i] && k < 200) begin
      tick();
      k++;
    end
    chk(tag, 32'(done[i]), 32'd1);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    rst    = 1'b1;
    start  = '0;
    up_s0_valid  = '0;
    act_s0_ready = '0;
    act_s1_valid = '0;
    dn_s1_ready  = '0;
    act_s2_valid = '0;
    dn_s2_ready  = '0;
    for (int i = 0; i < 3; i++) begin
      n_fire[i]      = '0;
      up_s0_data[i]  = 32'hA000_0000 + 32'(i);
      act_s1_data[i] = 32'hB100_0000 + 32'(i);
      act_s2_data[i] = 32'hC200_0000 + 32'(i);
    end
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_s0", 32'({act_s0_valid, up_s0_ready}), 32'd0);
    chk("rst_s1", 32'({dn_s1_valid, act_s1_ready}), 32'd0);
    chk("rst_s2", 32'({dn_s2_valid, act_s2_ready}), 32'd0);
    chk("rst_fc", 32'(fire_count[0]), 32'd0);
    rst = 1'b0;

    up_s0_valid  = '1;
    act_s0_ready = '1;
    act_s1_valid = '1;
    dn_s1_ready  = '1;
    act_s2_valid = '1;
    dn_s2_ready  = '1;
    tick();
    chk("idle_gated", 32'(nv[0] + nv[1] + nv[2]), 32'd0);

    // rates 2/1/3, two firings, free-flowing streams
    snap(0);
    pulse(0, 16'd2);
    chk("a_busy", 32'(busy[0]), 32'd1);
    chk("a_s0_data", act_s0_data[0], 32'hA000_0000);
    wait_done(0, "a_done_to");
    chk("a_fc", 32'(fire_count[0]), 32'd2);
    chk("a_busy_done", 32'(busy[0]), 32'd0);
    chk("a_n0", 32'(n0[0] - b0), 32'd4);
    chk("a_n1", 32'(n1[0] - b1), 32'd2);
    chk("a_n2", 32'(n2[0] - b2), 32'd6);
    tick();
    chk("a_done_len", 32'(done[0]), 32'd0);
    chk("a_nd", 32'(nd[0] - bd), 32'd1);

    // zero-length run
    snap(0);
    pulse(0, 16'd0);
    chk("z_done", 32'(done[0]), 32'd1);
    chk("z_busy", 32'(busy[0]), 32'd0);
    chk("z_fc", 32'(fire_count[0]), 32'd0);
    tick();
    chk("z_done_len", 32'(done[0]), 32'd0);
    chk("z_novalid", 32'(nv[0] - bv), 32'd0);

    // s2 backpressure in firing 1, plus a start while busy
    snap(1);
    dn_s2_ready[1] = 1'b0;
    pulse(1, 16'd3);
    repeat (4) tick();
    pulse(1, 16'd7);
    repeat (4) tick();
    chk("b_busy", 32'(busy[1]), 32'd1);
    chk("b_n0", 32'(n0[1] - b0), 32'd1);
    chk("b_n1", 32'(n1[1] - b1), 32'd1);
    chk("b_n2", 32'(n2[1] - b2), 32'd0);
    chk("b_s1_off", 32'({dn_s1_valid[1], act_s1_ready[1]}), 32'd0);
    chk("b_s2_vld", 32'(dn_s2_valid[1]), 32'd1);
    chk("b_s2_rdy", 32'(act_s2_ready[1]), 32'd0);
    chk("b_s0_rdy", 32'(up_s0_ready[1]), 32'd0);
    dn_s2_ready[1] = 1'b1;
    wait_done(1, "b_done_to");
    chk("b_fc", 32'(fire_count[1]), 32'd3);
    chk("b_n0_end", 32'(n0[1] - b0), 32'd3);
    chk("b_n2_end", 32'(n2[1] - b2), 32'd3);
    repeat (3) tick();
    chk("b_nd", 32'(nd[1] - bd), 32'd1);
    chk("b_fc_hold", 32'(fire_count[1]), 32'd3);
    chk("b_idle", 32'({busy[1], done[1]}), 32'd0);

    // reset after the second consume beat
    snap(1);
    pulse(1, 16'd5);
    for (int k = 0; k < 20 && (n0[1] - b0) < 2; k++) tick();
    chk("r_beats", 32'(n0[1] - b0), 32'd2);
    rst = 1'b1;
    #1;
    chk("r_busy", 32'(busy[1]), 32'd0);
    chk("r_s0", 32'({act_s0_valid[1], up_s0_ready[1]}), 32'd0);
    chk("r_s1", 32'({dn_s1_valid[1], act_s1_ready[1]}), 32'd0);
    chk("r_s2", 32'({dn_s2_valid[1], act_s2_ready[1]}), 32'd0);
    chk("r_fc", 32'(fire_count[1]), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    snap(1);
    pulse(1, 16'd1);
    wait_done(1, "r2_done_to");
    chk("r2_fc", 32'(fire_count[1]), 32'd1);
    chk("r2_n", 32'((n0[1] - b0) * 100 + (n1[1] - b1) * 10
                    + (n2[1] - b2)), 32'd111);

    // rates 1/2/2: both output streams end on the same beat
    snap(2);
    pulse(2, 16'd2);
    chk("c_cons", 32'(up_s0_ready[2]), 32'd1);
    tick();
    chk("c_prod", 32'({dn_s1_valid[2], dn_s2_valid[2]}), 32'd3);
    chk("c_s0_off", 32'(up_s0_ready[2]), 32'd0);
    chk("c_s1_data", dn_s1_data[2], 32'hB100_0002);
    chk("c_s2_data", dn_s2_data[2], 32'hC200_0002);
    tick();
    chk("c_fc_mid", 32'(fire_count[2]), 32'd0);
    tick();
    chk("c_fc_inc", 32'(fire_count[2]), 32'd1);
    chk("c_back_cons", 32'(up_s0_ready[2]), 32'd1);
    chk("c_prod_off", 32'({dn_s1_valid[2], dn_s2_valid[2]}), 32'd0);
    wait_done(2, "c_done_to");
    chk("c_fc", 32'(fire_count[2]), 32'd2);
    chk("c_n12", 32'((n1[2] - b1) * 10 + (n2[2] - b2)), 32'd44);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
